bp_fe_queue_ckpt_fifo: RTL and testbench

BP_FE_QUEUE_CKPT_FIFO -- requirements
Module: bp_fe_queue_ckpt_fifo

---
 rtl/bp_common_pkg.sv | 13 +
 rtl/bp_fe_queue_ckpt_mem.sv | 24 ++
 rtl/bp_fe_queue_ckpt_fifo.sv | 78 +++++++
 tb/tb_bp_fe_queue_ckpt_fifo.sv | 136 +++++++++++++
 4 files changed

// File: rtl/bp_common_pkg.sv
// Shared front-end definitions: FE-queue entry type and pointer sizing helper.
// The pointer carries one extra wrap bit above the index so full and empty stay distinct.
package bp_common_pkg;

  localparam int fe_queue_width_lp = 8;

  typedef logic [fe_queue_width_lp-1:0] bp_fe_queue_s;

  function automatic int fe_queue_ptr_width(input int els);
    return $clog2(els) + 1;
  endfunction

endpackage

// File: rtl/bp_fe_queue_ckpt_mem.sv
// FE-queue storage: 1r1w register file, synchronous write, asynchronous read.
// Contents are never reset; validity is tracked entirely by the owner's pointers.
module bp_fe_queue_ckpt_mem #(
  parameter int width_p = 8,
  parameter int els_p   = 16,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 w_v_i,
  input  logic [lg_els_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]   w_data_i,
  input  logic [lg_els_lp-1:0] r_addr_i,
  output logic [width_p-1:0]   r_data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_fe_queue_ckpt_fifo.sv
// Checkpointed FE->BE queue: entries stay resident after being read until committed, so reads can be rolled back.
// Latency: enqueue-to-v_o 1 cycle (0 with BP_FE_QUEUE_CKPT_FIFO_BYPASS_EN when empty).
// Backpressure: ready_o is registered-only; space frees the cycle after a ckpt or clr.
module bp_fe_queue_ckpt_fifo
  import bp_common_pkg::*;
#(
  parameter int width_p = fe_queue_width_lp,
  parameter int els_p   = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,
  input  logic               ckpt_v_i,
  input  logic               roll_v_i,
  input  logic               clr_v_i
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam int ptr_width_lp = fe_queue_ptr_width(els_p);
  localparam logic [ptr_width_lp-1:0] full_dist_lp = ptr_width_lp'(els_p);

  logic [ptr_width_lp-1:0] wptr, rptr, cptr, cptr_n;
  logic [width_p-1:0]      mem_data;
  logic                    enq, empty;

  assign cptr_n  = ckpt_v_i ? cptr + 1'b1 : cptr;
  assign ready_o = ((wptr - cptr) != full_dist_lp);
  assign empty   = (rptr == wptr);
  assign enq     = v_i & ready_o & ~clr_v_i;

`ifdef BP_FE_QUEUE_CKPT_FIFO_BYPASS_EN
  assign v_o    = ~empty | enq;
  assign data_o = empty ? data_i : mem_data;
`else
  assign v_o    = ~empty;
  assign data_o = mem_data;
`endif

  bp_fe_queue_ckpt_mem #(
    .width_p (width_p),
    .els_p   (els_p)
  ) mem (
    .clk_i    (clk_i),
    .w_v_i    (enq & reset_n_i),
    .w_addr_i (wptr[lg_els_lp-1:0]),
    .w_data_i (data_i),
    .r_addr_i (rptr[lg_els_lp-1:0]),
    .r_data_o (mem_data)
  );

  // Priority: clr over roll over yumi; the checkpoint advance always lands.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else begin
      cptr <= cptr_n;
      if (clr_v_i) begin
        rptr <= cptr_n;
        wptr <= cptr_n;
      end else begin
        if (enq)           wptr <= wptr + 1'b1;
        if (roll_v_i)      rptr <= cptr_n;
        else if (yumi_i)   rptr <= rptr + 1'b1;
      end
    end
  end

  ckpt_past_read: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(ckpt_v_i && (cptr == rptr)));

endmodule

// File: tb/tb_bp_fe_queue_ckpt_fifo.sv
// Directed bench for the checkpointed FE queue at els_p=4, width_p=8.
module tb_bp_fe_queue_ckpt_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic       v_in;
  logic       ready;
  logic [7:0] data_out;
  logic       v_out;
  logic       yumi, ckpt_v, roll_v, clr_v;

  int checks = 0;
  int errors = 0;

  bp_fe_queue_ckpt_fifo #(.width_p(8), .els_p(4)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .data_i    (data_in),
    .v_i       (v_in),
    .ready_o   (ready),
    .data_o    (data_out),
    .v_o       (v_out),
    .yumi_i    (yumi),
    .ckpt_v_i  (ckpt_v),
    .roll_v_i  (roll_v),
    .clr_v_i   (clr_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    v_in = 1'b0; data_in = 8'h00; yumi = 1'b0;
    ckpt_v = 1'b0; roll_v = 1'b0; clr_v = 1'b0;
  endtask

  // Apply current inputs across one rising edge, then return inputs to idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic enqueue(input logic [7:0] val);
    v_in = 1'b1; data_in = val;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    step();
    step();
    reset_n = 1'b1;
    check("reset_ready", {7'b0, ready}, 8'd1);
    check("reset_v_o",   {7'b0, v_out}, 8'd0);

    // Fill
    enqueue(8'h11);
    check("fill1_v_o",   {7'b0, v_out}, 8'd1);
    check("fill1_data",  data_out, 8'h11);
    check("fill1_ready", {7'b0, ready}, 8'd1);
    enqueue(8'h22);
    enqueue(8'h33);
    enqueue(8'h44);
    check("full_ready", {7'b0, ready}, 8'd0);
    check("full_v_o",   {7'b0, v_out}, 8'd1);
    check("full_data",  data_out, 8'h11);

    // Rollback
    yumi = 1'b1; step();
    check("yumi1_data", data_out, 8'h22);
    yumi = 1'b1; step();
    check("yumi2_data", data_out, 8'h33);
    roll_v = 1'b1; yumi = 1'b1; step();
    check("roll_data",  data_out, 8'h11);
    check("roll_ready", {7'b0, ready}, 8'd0);

    // Checkpoint and rollback in the same cycle
    yumi = 1'b1; step();
    check("yumi3_data", data_out, 8'h22);
    ckpt_v = 1'b1; roll_v = 1'b1; step();
    check("ckroll_data",  data_out, 8'h22);
    check("ckroll_ready", {7'b0, ready}, 8'd1);

    // Clear drops the same-cycle enqueue
    clr_v = 1'b1; v_in = 1'b1; data_in = 8'h99; step();
    check("clr_v_o",   {7'b0, v_out}, 8'd0);
    check("clr_ready", {7'b0, ready}, 8'd1);
    enqueue(8'h55);
    check("post_clr_v_o", {7'b0, v_out}, 8'd1);
    check("post_clr_data", data_out, 8'h55);
    yumi = 1'b1; step();
    check("drain_v_o", {7'b0, v_out}, 8'd0);
    ckpt_v = 1'b1; step();

    // Wrap: pointers cycle past 2*els_p
    for (int i = 0; i < 10; i++) begin
      enqueue(8'(i));
      check("wrap_v_o",   {7'b0, v_out}, 8'd1);
      check("wrap_data",  data_out, 8'(i));
      check("wrap_ready", {7'b0, ready}, 8'd1);
      yumi = 1'b1; step();
      check("wrap_empty", {7'b0, v_out}, 8'd0);
      ckpt_v = 1'b1; step();
      check("wrap_free", {7'b0, ready}, 8'd1);
    end

    // Mid-operation reset with the queue full; inputs during reset are ignored
    for (int i = 0; i < 4; i++) enqueue(8'hA0 + 8'(i));
    check("refill_ready", {7'b0, ready}, 8'd0);
    check("refill_data",  data_out, 8'hA0);
    reset_n = 1'b0; v_in = 1'b1; data_in = 8'hEE; yumi = 1'b1;
    step();
    reset_n = 1'b1;
    check("mid_rst_ready", {7'b0, ready}, 8'd1);
    check("mid_rst_v_o",   {7'b0, v_out}, 8'd0);
    enqueue(8'hB1);
    enqueue(8'hB2);
    check("mid_rst_first", data_out, 8'hB1);
    yumi = 1'b1; step();
    check("mid_rst_second", data_out, 8'hB2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
